// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register and writeback logic for the RV32I 5-stage core.
//
// Purpose:
//   Latches the MEM-stage result, extracts and extends load data from the
//   data-memory read word, drives the register-file write port, counts retired
//   instructions and flags misaligned or illegal loads.
//
// Ports:
//   clk              core clock, rising-edge
//   rst              synchronous active-low reset
//   mem_valid_i      MEM stage holds a valid instruction
//   mem_reg_wen_i    instruction writes rd
//   mem_reg_waddr_i  rd index
//   mem_result_i     ALU result / load effective address
//   mem_is_load_i    instruction is a load
//   mem_funct3_i     load type encoding
//   dmem_rdata_i     data-memory read word, valid while the load sits in WB
//   stall_i          hold WB register contents
//   flush_i          kill the instruction entering WB
//   reg_waddr_o      register file write address
//   reg_wdata_o      register file write data
//   reg_wen_o        register file write enable
//   wb_valid_o       WB holds a valid instruction
//   load_misalign_o  WB load is misaligned or has an illegal funct3
//   instret_o        retired-instruction count
module wb_stage #(
    parameter int unsigned CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_valid_i,
    input  logic             mem_reg_wen_i,
    input  logic [4:0]       mem_reg_waddr_i,
    input  logic [31:0]      mem_result_i,
    input  logic             mem_is_load_i,
    input  logic [2:0]       mem_funct3_i,
    input  logic [31:0]      dmem_rdata_i,
    input  logic             stall_i,
    input  logic             flush_i,
    output logic [4:0]       reg_waddr_o,
    output logic [31:0]      reg_wdata_o,
    output logic             reg_wen_o,
    output logic             wb_valid_o,
    output logic             load_misalign_o,
    output logic [CNT_W-1:0] instret_o
);

    logic             valid_q;
    logic             wen_q;
    logic [4:0]       waddr_q;
    logic [31:0]      result_q;
    logic             is_load_q;
    logic [2:0]       funct3_q;
    logic [CNT_W-1:0] cnt_q;

    logic [1:0]  off;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic        misaligned;
    logic        illegal;
    logic        retire;

    // Pipeline register: reset, then flush, then stall, then load.
    always_ff @(posedge clk) begin
        if (!rst || flush_i) begin
            valid_q   <= 1'b0;
            wen_q     <= 1'b0;
            waddr_q   <= 5'd0;
            result_q  <= 32'd0;
            is_load_q <= 1'b0;
            funct3_q  <= 3'd0;
        end else if (!stall_i) begin
            valid_q   <= mem_valid_i;
            wen_q     <= mem_reg_wen_i;
            waddr_q   <= mem_reg_waddr_i;
            result_q  <= mem_result_i;
            is_load_q <= mem_is_load_i;
            funct3_q  <= mem_funct3_i;
        end
    end

    // Load extraction and alignment check.
    always_comb begin
        off        = result_q[1:0];
        ld_byte    = 8'd0;
        ld_half    = off[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        ld_data    = 32'd0;
        misaligned = 1'b0;
        illegal    = 1'b0;
        unique case (off)
            2'd0: ld_byte = dmem_rdata_i[7:0];
            2'd1: ld_byte = dmem_rdata_i[15:8];
            2'd2: ld_byte = dmem_rdata_i[23:16];
            2'd3: ld_byte = dmem_rdata_i[31:24];
            default: ld_byte = 8'd0;
        endcase
        case (funct3_q)
            3'b000: ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100: ld_data = {24'd0, ld_byte};
            3'b001: begin
                ld_data    = {{16{ld_half[15]}}, ld_half};
                misaligned = off[0];
            end
            3'b101: begin
                ld_data    = {16'd0, ld_half};
                misaligned = off[0];
            end
            3'b010: begin
                ld_data    = dmem_rdata_i;
                misaligned = (off != 2'd0);
            end
            default: illegal = 1'b1;
        endcase
    end

    assign load_misalign_o = valid_q & is_load_q & (misaligned | illegal);
    assign reg_wdata_o     = is_load_q ? ld_data : result_q;
    assign reg_wen_o       = valid_q & wen_q & (waddr_q != 5'd0) & ~load_misalign_o;
    assign reg_waddr_o     = waddr_q;
    assign wb_valid_o      = valid_q;

    // A flush kills only the incoming instruction, so it does not gate retire.
    assign retire = valid_q & ~stall_i & ~load_misalign_o;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (retire) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign instret_o = cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed self-checking bench for wb_stage.
// Two instances share stimulus: default counter width and a 4-bit counter for wrap.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid_i;
    logic        mem_reg_wen_i;
    logic [4:0]  mem_reg_waddr_i;
    logic [31:0] mem_result_i;
    logic        mem_is_load_i;
    logic [2:0]  mem_funct3_i;
    logic [31:0] dmem_rdata_i;
    logic        stall_i;
    logic        flush_i;

    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o;
    logic        reg_wen_o;
    logic        wb_valid_o;
    logic        load_misalign_o;
    logic [63:0] instret_o;

    logic [4:0]  n_waddr;
    logic [31:0] n_wdata;
    logic        n_wen;
    logic        n_valid;
    logic        n_misalign;
    logic [3:0]  n_instret;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [63:0] exp_cnt;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk             (clk),
        .rst             (rst),
        .mem_valid_i     (mem_valid_i),
        .mem_reg_wen_i   (mem_reg_wen_i),
        .mem_reg_waddr_i (mem_reg_waddr_i),
        .mem_result_i    (mem_result_i),
        .mem_is_load_i   (mem_is_load_i),
        .mem_funct3_i    (mem_funct3_i),
        .dmem_rdata_i    (dmem_rdata_i),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .reg_waddr_o     (reg_waddr_o),
        .reg_wdata_o     (reg_wdata_o),
        .reg_wen_o       (reg_wen_o),
        .wb_valid_o      (wb_valid_o),
        .load_misalign_o (load_misalign_o),
        .instret_o       (instret_o)
    );

    wb_stage #(.CNT_W(4)) dut_narrow (
        .clk             (clk),
        .rst             (rst),
        .mem_valid_i     (mem_valid_i),
        .mem_reg_wen_i   (mem_reg_wen_i),
        .mem_reg_waddr_i (mem_reg_waddr_i),
        .mem_result_i    (mem_result_i),
        .mem_is_load_i   (mem_is_load_i),
        .mem_funct3_i    (mem_funct3_i),
        .dmem_rdata_i    (dmem_rdata_i),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .reg_waddr_o     (n_waddr),
        .reg_wdata_o     (n_wdata),
        .reg_wen_o       (n_wen),
        .wb_valid_o      (n_valid),
        .load_misalign_o (n_misalign),
        .instret_o       (n_instret)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction to MEM for one edge, then leave a bubble behind it.
    task automatic issue(input logic wen, input logic [4:0] rd, input logic [31:0] res,
                         input logic ld, input logic [2:0] f3);
        mem_valid_i     = 1'b1;
        mem_reg_wen_i   = wen;
        mem_reg_waddr_i = rd;
        mem_result_i    = res;
        mem_is_load_i   = ld;
        mem_funct3_i    = f3;
        step();
        mem_valid_i     = 1'b0;
    endtask

    // Good load / ALU op sitting in WB: write enabled, data as given, no misalign flag.
    task automatic check_good(input string tag, input logic [31:0] data);
        check({tag, "_wen"}, 64'(reg_wen_o), 64'd1);
        check({tag, "_wdata"}, 64'(reg_wdata_o), 64'(data));
        check({tag, "_mis"}, 64'(load_misalign_o), 64'd0);
        check({tag, "_instret"}, instret_o, exp_cnt);
    endtask

    task automatic check_bad(input string tag);
        check({tag, "_wen"}, 64'(reg_wen_o), 64'd0);
        check({tag, "_mis"}, 64'(load_misalign_o), 64'd1);
        check({tag, "_instret"}, instret_o, exp_cnt);
    endtask

    initial begin
        rst             = 1'b0;
        mem_valid_i     = 1'b0;
        mem_reg_wen_i   = 1'b0;
        mem_reg_waddr_i = 5'd0;
        mem_result_i    = 32'd0;
        mem_is_load_i   = 1'b0;
        mem_funct3_i    = 3'd0;
        dmem_rdata_i    = 32'h80FF7F01;
        stall_i         = 1'b0;
        flush_i         = 1'b0;
        exp_cnt         = 64'd0;

        step();
        step();
        rst = 1'b1;
        check("rst_valid", 64'(wb_valid_o), 64'd0);
        check("rst_wen", 64'(reg_wen_o), 64'd0);
        check("rst_instret", instret_o, 64'd0);

        // ALU write, 1-cycle latency, counter visible one cycle later.
        issue(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 3'b000);
        check_good("alu", 32'hDEADBEEF);
        check("alu_waddr", 64'(reg_waddr_o), 64'd5);
        check("alu_valid", 64'(wb_valid_o), 64'd1);
        step();
        exp_cnt = 64'd1;
        check("alu_instret_after", instret_o, exp_cnt);
        check("alu_bubble_valid", 64'(wb_valid_o), 64'd0);

        // Loads from 0x80FF7F01.
        issue(1'b1, 5'd6, 32'h00001003, 1'b1, 3'b000);
        check_good("lb3", 32'hFFFFFF80);
        exp_cnt++;
        issue(1'b1, 5'd6, 32'h00001003, 1'b1, 3'b100);
        check_good("lbu3", 32'h00000080);
        exp_cnt++;
        issue(1'b1, 5'd6, 32'h00001002, 1'b1, 3'b001);
        check_good("lh2", 32'hFFFF80FF);
        exp_cnt++;
        issue(1'b1, 5'd6, 32'h00001000, 1'b1, 3'b101);
        check_good("lhu0", 32'h00007F01);
        exp_cnt++;
        issue(1'b1, 5'd6, 32'h00001000, 1'b1, 3'b010);
        check_good("lw0", 32'h80FF7F01);
        exp_cnt++;

        // Misaligned / illegal loads do not write or retire.
        issue(1'b1, 5'd6, 32'h00001002, 1'b1, 3'b010);
        check_bad("lw2");
        issue(1'b1, 5'd6, 32'h00001001, 1'b1, 3'b001);
        check_bad("lh1");
        issue(1'b1, 5'd6, 32'h00001000, 1'b1, 3'b011);
        check_bad("f3_011");

        // Unaligned ALU result is not a load fault.
        issue(1'b1, 5'd10, 32'h00000003, 1'b0, 3'b010);
        check_good("alu_odd", 32'h00000003);
        exp_cnt++;

        // rd = x0: no write, still retires.
        issue(1'b1, 5'd0, 32'h00001234, 1'b0, 3'b000);
        check("x0_wen", 64'(reg_wen_o), 64'd0);
        check("x0_wdata", 64'(reg_wdata_o), 64'h1234);
        check("x0_instret", instret_o, exp_cnt);
        exp_cnt++;

        // Stall for three edges with different data waiting in MEM.
        issue(1'b1, 5'd7, 32'h0000A5A5, 1'b0, 3'b000);
        check_good("stall_pre", 32'h0000A5A5);
        stall_i         = 1'b1;
        mem_valid_i     = 1'b1;
        mem_reg_waddr_i = 5'd9;
        mem_result_i    = 32'h00000BAD;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_wdata", 64'(reg_wdata_o), 64'h0000A5A5);
            check("stall_waddr", 64'(reg_waddr_o), 64'd7);
            check("stall_wen", 64'(reg_wen_o), 64'd1);
            check("stall_instret", instret_o, exp_cnt);
        end
        stall_i     = 1'b0;
        mem_valid_i = 1'b0;
        step();
        exp_cnt++;
        check("stall_release_instret", instret_o, exp_cnt);
        check("stall_release_valid", 64'(wb_valid_o), 64'd0);

        // Flush alone: leaving instruction retires, entering one is killed.
        issue(1'b1, 5'd11, 32'h00000055, 1'b0, 3'b000);
        flush_i     = 1'b1;
        mem_valid_i = 1'b1;
        step();
        flush_i     = 1'b0;
        mem_valid_i = 1'b0;
        exp_cnt++;
        check("flush_valid", 64'(wb_valid_o), 64'd0);
        check("flush_instret", instret_o, exp_cnt);

        // Flush with stall: flush wins, stalled instruction does not retire.
        issue(1'b1, 5'd12, 32'h00000066, 1'b0, 3'b000);
        flush_i     = 1'b1;
        stall_i     = 1'b1;
        mem_valid_i = 1'b1;
        step();
        flush_i     = 1'b0;
        stall_i     = 1'b0;
        mem_valid_i = 1'b0;
        check("flush_stall_valid", 64'(wb_valid_o), 64'd0);
        check("flush_stall_wen", 64'(reg_wen_o), 64'd0);
        check("flush_stall_instret", instret_o, exp_cnt);

        // Reset with instret = 7 and a valid instruction stalled in WB.
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("rst2_instret", instret_o, 64'd0);
        for (int i = 0; i < 8; i++) begin
            issue(1'b1, 5'd1, 32'(i), 1'b0, 3'b000);
        end
        check("pre_rst_instret", instret_o, 64'd7);
        check("pre_rst_valid", 64'(wb_valid_o), 64'd1);
        stall_i = 1'b1;
        rst     = 1'b0;
        step();
        rst     = 1'b1;
        stall_i = 1'b0;
        check("post_rst_valid", 64'(wb_valid_o), 64'd0);
        check("post_rst_wen", 64'(reg_wen_o), 64'd0);
        check("post_rst_instret", instret_o, 64'd0);
        check("post_rst_narrow", 64'(n_instret), 64'd0);

        // 17 back-to-back retires: 4-bit counter wraps to 1.
        mem_valid_i     = 1'b1;
        mem_reg_wen_i   = 1'b1;
        mem_reg_waddr_i = 5'd3;
        mem_is_load_i   = 1'b0;
        repeat (17) step();
        mem_valid_i = 1'b0;
        step();
        check("wrap_narrow", 64'(n_instret), 64'd1);
        check("wrap_wide", instret_o, 64'd17);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB pipeline register plus writeback logic for the RV32I 5-stage core. Sits directly upstream of the general-purpose register file write port.
- Latches the MEM-stage result, extracts and extends load data from the data-memory read word, and drives the register-file write port.
- Also exports a retired-instruction counter (minstret source) and a load-misalignment flag.

Parameters:
- CNT_W, 64, width of retired-instruction counter

Ports:
- clk  input  1  core clock, all state updates on rising edge
- rst  input  1  reset; synchronous, active-low (rst==0 resets on the next rising clk edge)
- mem_valid_i  input  1  MEM stage holds a valid instruction
- mem_reg_wen_i  input  1  instruction writes rd
- mem_reg_waddr_i  input  5  rd index
- mem_result_i  input  32  ALU result / effective address for loads
- mem_is_load_i  input  1  instruction is a load
- mem_funct3_i  input  3  load type (LB/LH/LW/LBU/LHU encodings)
- dmem_rdata_i  input  32  data-memory read word; synchronous RAM, valid in the cycle the load occupies WB
- stall_i  input  1  hold WB register contents
- flush_i  input  1  kill the instruction entering WB
- reg_waddr_o  output  5  to register file write address
- reg_wdata_o  output  32  to register file write data
- reg_wen_o  output  1  to register file write enable
- wb_valid_o  output  1  WB holds a valid instruction (for hazard/forward units)
- load_misalign_o  output  1  WB load is misaligned or has an illegal funct3
- instret_o  output  CNT_W  retired-instruction count

Behaviour:
- State:
  - Pipeline register: valid_q, wen_q, waddr_q[4:0], result_q[31:0], is_load_q, funct3_q[2:0].
  - Counter: cnt_q[CNT_W-1:0].
- Update priority at posedge clk:
  - rst==0: all state cleared to 0.
  - else flush_i: valid_q<=0, other fields don't-care (cleared to 0).
  - else stall_i: hold all fields.
  - else: load all fields from mem_* inputs; valid_q<=mem_valid_i.
  - flush_i and stall_i both set: flush wins.
- Byte offset off = result_q[1:0].
- Load extraction (combinational, from dmem_rdata_i):
  - 000 LB: byte at off, sign-extended.
  - 100 LBU: byte at off, zero-extended.
  - 001 LH: halfword at off[1] (bits 15:0 or 31:16), sign-extended; off==1 or off==3 is misaligned.
  - 101 LHU: as LH, zero-extended.
  - 010 LW: full word; off!=0 is misaligned.
  - 011, 110, 111: illegal.
- load_misalign_o = valid_q & is_load_q & (misaligned | illegal). Combinational, asserted for as long as the instruction sits in WB.
- reg_wdata_o = extracted load data if is_load_q, else result_q.
- reg_wen_o = valid_q & wen_q & (waddr_q!=0) & ~load_misalign_o.
- reg_waddr_o = waddr_q.
- Write port is combinational from the WB register, so the register file's same-cycle write-through bypass sees the data in the same cycle.
- wb_valid_o = valid_q.
- Repeated assertion of reg_wen_o during stall is permitted; it rewrites the same value.
- Retire event = valid_q & ~stall_i & ~load_misalign_o.
  - cnt_q increments by 1 per retire event and wraps modulo 2^CNT_W.
  - instret_o = cnt_q, a registered value: a retire in cycle N is visible in cycle N+1.
  - flush_i does not suppress the retire of the instruction currently leaving WB; it only kills the one entering.
- Reset mid-stall or mid-load: everything cleared. reg_wen_o=0 and instret_o=0 in the cycle after the reset edge.
- Latency: mem_* to reg_* outputs is 1 cycle.

Test Plan:
- ALU write: valid, wen, rd=5, result=0xDEADBEEF, no stall → next cycle reg_wen_o=1, waddr=5, wdata=0xDEADBEEF; instret 0→1 one cycle later.
- Loads: dmem_rdata_i=0x80FF7F01.
  - LB off=3 → 0xFFFFFF80.
  - LBU off=3 → 0x00000080.
  - LH off=2 → 0xFFFF80FF.
  - LHU off=0 → 0x00007F01.
  - LW off=0 → 0x80FF7F01.
- Misaligned: LW off=2, or LH off=1, or funct3=011 → load_misalign_o=1, reg_wen_o=0, instret unchanged.
- rd=x0: wen=1, rd=0, result=0x1234 → reg_wen_o=0; instret still increments.
- Stall/flush:
  - stall_i held 3 cycles with a valid instruction in WB → outputs stable; instret increments once, on release.
  - flush_i with stall_i both set → WB valid drops next cycle.
- Reset: rst=0 for one edge while a valid instruction is in WB and instret=7 → next cycle wb_valid_o=0, reg_wen_o=0, instret_o=0.
- Counter wrap: with CNT_W=4, 17 retires → instret_o=1.
